aq_ifu_icache_tag_ctrl: RTL and testbench

AQ_IFU_ICACHE_TAG_CTRL -- requirements
Module: aq_ifu_icache_tag_ctrl

---
 rtl/aq_ifu_icache_tag_pkg.sv | 37 +++
 rtl/aq_ifu_icache_tag_cmp.sv | 13 +
 rtl/aq_ifu_icache_tag_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_aq_ifu_icache_tag_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aq_ifu_icache_tag_pkg.sv
// rtl/aq_ifu_icache_tag_pkg.sv - shared widths, entry field positions and FSM states for the icache tag controller
package aq_ifu_icache_tag_pkg;

   localparam int IDX_W = 8;
   localparam int TAG_W = 28;
   localparam int ENT_W = 2 * (TAG_W + 1) + 1;

   // Entry layout: {fifo, way1 valid, way1 tag, way0 valid, way0 tag}
   localparam int W0_TAG_LSB = 0;
   localparam int W0_VLD_BIT = TAG_W;
   localparam int W1_TAG_LSB = TAG_W + 1;
   localparam int W1_VLD_BIT = 2 * TAG_W + 1;
   localparam int FIFO_BIT   = 2 * TAG_W + 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_INV  = 1'b1
   } tag_st_e;

   // Field positions for a non-default tag width
   function automatic int f_w0_vld(input int tw);
      return tw;
   endfunction

   function automatic int f_w1_lsb(input int tw);
      return tw + 1;
   endfunction

   function automatic int f_w1_vld(input int tw);
      return 2 * tw + 1;
   endfunction

   function automatic int f_fifo(input int tw);
      return 2 * tw + 2;
   endfunction

endpackage

// File: rtl/aq_ifu_icache_tag_cmp.sv
// rtl/aq_ifu_icache_tag_cmp.sv - per-way valid+tag compare
module aq_ifu_icache_tag_cmp #(
   parameter int TAG_W = 28
) (
   input  logic             i_vld,
   input  logic [TAG_W-1:0] i_stor_tag,
   input  logic [TAG_W-1:0] i_lkup_tag,
   output logic             o_match
);

   assign o_match = i_vld & (i_stor_tag == i_lkup_tag);

endmodule

// File: rtl/aq_ifu_icache_tag_ctrl.sv
// rtl/aq_ifu_icache_tag_ctrl.sv - 2-way icache tag array controller; AQ_ICACHE_TAG_RST_INV_EN sweeps the array out of reset
module aq_ifu_icache_tag_ctrl #(
   parameter int IDX_W = aq_ifu_icache_tag_pkg::IDX_W,
   parameter int TAG_W = aq_ifu_icache_tag_pkg::TAG_W,
   parameter int ENT_W = aq_ifu_icache_tag_pkg::ENT_W
) (
   input  logic             forever_cpuclk,
   input  logic             cpurst_b,
   input  logic             lkup_vld,
   input  logic [IDX_W-1:0] lkup_idx,
   input  logic [TAG_W-1:0] lkup_tag,
   output logic             lkup_rdy,
   input  logic             refill_vld,
   input  logic [IDX_W-1:0] refill_idx,
   input  logic [TAG_W-1:0] refill_tag,
   input  logic             refill_way,
   output logic             refill_rdy,
   input  logic             inv_all_req,
   output logic             inv_busy,
   output logic             inv_done,
   output logic             rslt_vld,
   output logic             rslt_hit,
   output logic             rslt_way,
   output logic             rslt_victim,
   output logic [IDX_W-1:0] sram_a,
   output logic             sram_cen,
   output logic             sram_gwen,
   output logic [ENT_W-1:0] sram_d,
   output logic [ENT_W-1:0] sram_wen,
   input  logic [ENT_W-1:0] sram_q
);

   import aq_ifu_icache_tag_pkg::*;

   localparam int L_W0_LSB = 0;
   localparam int L_W0_VLD = f_w0_vld(TAG_W);
   localparam int L_W1_LSB = f_w1_lsb(TAG_W);
   localparam int L_W1_VLD = f_w1_vld(TAG_W);
   localparam int L_FIFO   = f_fifo(TAG_W);
   localparam logic [IDX_W-1:0] LAST_IDX = '1;

`ifdef AQ_ICACHE_TAG_RST_INV_EN
   localparam tag_st_e RST_ST = ST_INV;
`else
   localparam tag_st_e RST_ST = ST_IDLE;
`endif

   tag_st_e          r_state;
   tag_st_e          w_nxt_state;
   logic [IDX_W-1:0] r_cnt;
   logic             r_inv_done;
   logic             r_lkup_issue;
   logic [TAG_W-1:0] r_lkup_tag;
   logic             w_inv_last;
   logic             w_lkup_acc;
   logic             w_m0;
   logic             w_m1;

   // State register; reset lands in IDLE, or straight into a sweep when configured
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_state <= RST_ST;
      end else begin
         r_state <= w_nxt_state;
      end
   end

   // Next state and the single SRAM access of the cycle: sweep > refill > lookup
   always_comb begin
      w_nxt_state = r_state;
      w_inv_last  = 1'b0;
      w_lkup_acc  = 1'b0;
      lkup_rdy    = 1'b0;
      refill_rdy  = 1'b0;
      sram_a      = '0;
      sram_cen    = 1'b1;
      sram_gwen   = 1'b1;
      sram_d      = '0;
      sram_wen    = '1;
      // SRAM stays untouched while reset is held, even if the state register sits in INV
      if (cpurst_b) begin
         case (r_state)
            ST_INV: begin
               sram_a     = r_cnt;
               sram_cen   = 1'b0;
               sram_gwen  = 1'b0;
               sram_wen   = '0;
               w_inv_last = (r_cnt == LAST_IDX);
               if (w_inv_last) begin
                  w_nxt_state = ST_IDLE;
               end
            end
            default: begin
               refill_rdy = 1'b1;
               lkup_rdy   = ~refill_vld;
               if (inv_all_req) begin
                  w_nxt_state = ST_INV;
               end
               if (refill_vld) begin
                  sram_a           = refill_idx;
                  sram_cen         = 1'b0;
                  sram_gwen        = 1'b0;
                  // Point the replacement bit at the other way
                  sram_d[L_FIFO]   = ~refill_way;
                  sram_wen[L_FIFO] = 1'b0;
                  if (refill_way) begin
                     sram_d[L_W1_VLD]                 = 1'b1;
                     sram_d[L_W1_LSB +: TAG_W]        = refill_tag;
                     sram_wen[L_W1_VLD]               = 1'b0;
                     sram_wen[L_W1_LSB +: TAG_W]      = '0;
                  end else begin
                     sram_d[L_W0_VLD]                 = 1'b1;
                     sram_d[L_W0_LSB +: TAG_W]        = refill_tag;
                     sram_wen[L_W0_VLD]               = 1'b0;
                     sram_wen[L_W0_LSB +: TAG_W]      = '0;
                  end
               end else if (lkup_vld) begin
                  w_lkup_acc = 1'b1;
                  sram_a     = lkup_idx;
                  sram_cen   = 1'b0;
               end
            end
         endcase
      end
   end

   // Sweep index: runs only in INV, wraps to 0 after the last set
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_cnt <= '0;
      end else if (r_state == ST_INV) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

   // One-cycle done pulse after the final sweep write
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_inv_done <= 1'b0;
      end else begin
         r_inv_done <= w_inv_last;
      end
   end

   // Remember an issued lookup so the result lines up with sram_q next cycle
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_lkup_issue <= 1'b0;
         r_lkup_tag   <= '0;
      end else begin
         r_lkup_issue <= w_lkup_acc;
         if (w_lkup_acc) begin
            r_lkup_tag <= lkup_tag;
         end
      end
   end

   aq_ifu_icache_tag_cmp #(.TAG_W(TAG_W)) u_cmp0 (
      .i_vld      (sram_q[L_W0_VLD]),
      .i_stor_tag (sram_q[L_W0_LSB +: TAG_W]),
      .i_lkup_tag (r_lkup_tag),
      .o_match    (w_m0)
   );

   aq_ifu_icache_tag_cmp #(.TAG_W(TAG_W)) u_cmp1 (
      .i_vld      (sram_q[L_W1_VLD]),
      .i_stor_tag (sram_q[L_W1_LSB +: TAG_W]),
      .i_lkup_tag (r_lkup_tag),
      .o_match    (w_m1)
   );

   assign inv_busy    = (r_state == ST_INV) & cpurst_b;
   assign inv_done    = r_inv_done;
   assign rslt_vld    = r_lkup_issue;
   assign rslt_hit    = w_m0 | w_m1;
   assign rslt_way    = w_m1 & ~w_m0;
   // Fill an empty way first, otherwise follow the FIFO bit
   assign rslt_victim = ~sram_q[L_W0_VLD] ? 1'b0 :
                        ~sram_q[L_W1_VLD] ? 1'b1 : sram_q[L_FIFO];

endmodule

// File: tb/tb_aq_ifu_icache_tag_ctrl.sv
// tb/tb_aq_ifu_icache_tag_ctrl.sv - directed self-checking bench for the icache tag controller
module tb_aq_ifu_icache_tag_ctrl;

   logic        clk;
   logic        rst_b;
   logic        lkup_vld;
   logic [7:0]  lkup_idx;
   logic [27:0] lkup_tag;
   logic        lkup_rdy;
   logic        refill_vld;
   logic [7:0]  refill_idx;
   logic [27:0] refill_tag;
   logic        refill_way;
   logic        refill_rdy;
   logic        inv_all_req;
   logic        inv_busy;
   logic        inv_done;
   logic        rslt_vld;
   logic        rslt_hit;
   logic        rslt_way;
   logic        rslt_victim;
   logic [7:0]  sram_a;
   logic        sram_cen;
   logic        sram_gwen;
   logic [58:0] sram_d;
   logic [58:0] sram_wen;
   logic [58:0] sram_q;

   logic [58:0] mem [0:255];
   int n_chk;
   int n_pass;
   int n_fail;

   aq_ifu_icache_tag_ctrl u_dut (
      .forever_cpuclk (clk),
      .cpurst_b       (rst_b),
      .lkup_vld       (lkup_vld),
      .lkup_idx       (lkup_idx),
      .lkup_tag       (lkup_tag),
      .lkup_rdy       (lkup_rdy),
      .refill_vld     (refill_vld),
      .refill_idx     (refill_idx),
      .refill_tag     (refill_tag),
      .refill_way     (refill_way),
      .refill_rdy     (refill_rdy),
      .inv_all_req    (inv_all_req),
      .inv_busy       (inv_busy),
      .inv_done       (inv_done),
      .rslt_vld       (rslt_vld),
      .rslt_hit       (rslt_hit),
      .rslt_way       (rslt_way),
      .rslt_victim    (rslt_victim),
      .sram_a         (sram_a),
      .sram_cen       (sram_cen),
      .sram_gwen      (sram_gwen),
      .sram_d         (sram_d),
      .sram_wen       (sram_wen),
      .sram_q         (sram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port SRAM with active-low bit write enables
   always @(posedge clk) begin
      if (!sram_cen) begin
         if (!sram_gwen) begin
            mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
         end else begin
            sram_q <= mem[sram_a];
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full sweep: every cycle must write zero to the next index; one done afterwards
   task automatic sweep(input bit send_req, input int reinv_at);
      int bad;
      int extra;
      bad   = 0;
      extra = 0;
      if (send_req) begin
         inv_all_req = 1'b1;
         #1;
         chk("busy_before_sweep", {63'd0, inv_busy}, 64'd0);
         step();
         inv_all_req = 1'b0;
      end
      for (int i = 0; i < 256; i++) begin
         if (i == reinv_at) inv_all_req = 1'b1;
         #1;
         if (sram_a !== i[7:0] || sram_cen !== 1'b0 || sram_gwen !== 1'b0 ||
             sram_wen !== 59'd0 || sram_d !== 59'd0 || inv_busy !== 1'b1) bad++;
         if (inv_done !== 1'b0) extra++;
         step();
         inv_all_req = 1'b0;
      end
      #1;
      chk("sweep_writes_bad", bad, 0);
      chk("inv_done_pulse", {63'd0, inv_done}, 64'd1);
      chk("inv_busy_after", {63'd0, inv_busy}, 64'd0);
      chk("idle_cen_after", {63'd0, sram_cen}, 64'd1);
      for (int i = 0; i < 8; i++) begin
         step();
         if (inv_done !== 1'b0 || inv_busy !== 1'b0) extra++;
      end
      chk("inv_done_extra", extra, 0);
   endtask

   task automatic refill(input logic [7:0] idx, input logic [27:0] tag, input logic way);
      refill_vld = 1'b1;
      refill_idx = idx;
      refill_tag = tag;
      refill_way = way;
      step();
      refill_vld = 1'b0;
   endtask

   task automatic lookup(input string name, input logic [7:0] idx, input logic [27:0] tag,
                         input logic e_hit, input logic e_way, input logic e_vic);
      lkup_vld = 1'b1;
      lkup_idx = idx;
      lkup_tag = tag;
      #1;
      chk({name, "_rdy"}, {63'd0, lkup_rdy}, 64'd1);
      step();
      lkup_vld = 1'b0;
      #1;
      chk({name, "_vld"}, {63'd0, rslt_vld}, 64'd1);
      chk({name, "_hit"}, {63'd0, rslt_hit}, {63'd0, e_hit});
      if (e_hit) chk({name, "_way"}, {63'd0, rslt_way}, {63'd0, e_way});
      chk({name, "_victim"}, {63'd0, rslt_victim}, {63'd0, e_vic});
      step();
   endtask

   initial begin
      logic [58:0] e_wen;
      logic [58:0] e_d;
      int cnt;
      n_chk = 0;
      n_pass = 0;
      n_fail = 0;
      sram_q = '0;
      rst_b = 1'b0;
      lkup_vld = 1'b0;
      lkup_idx = '0;
      lkup_tag = '0;
      refill_vld = 1'b0;
      refill_idx = '0;
      refill_tag = '0;
      refill_way = 1'b0;
      inv_all_req = 1'b0;
      #2;
      chk("rst_rslt_vld", {63'd0, rslt_vld}, 64'd0);
      chk("rst_inv_busy", {63'd0, inv_busy}, 64'd0);
      chk("rst_inv_done", {63'd0, inv_done}, 64'd0);
      chk("rst_cen", {63'd0, sram_cen}, 64'd1);
      chk("rst_gwen", {63'd0, sram_gwen}, 64'd1);
      chk("rst_wen", {5'd0, sram_wen}, {5'd0, {59{1'b1}}});
      step();
      step();
      rst_b = 1'b1;
`ifdef AQ_ICACHE_TAG_RST_INV_EN
      sweep(1'b0, -1);
`else
      #1;
      chk("idle_lkup_rdy", {63'd0, lkup_rdy}, 64'd1);
      chk("idle_refill_rdy", {63'd0, refill_rdy}, 64'd1);
      chk("idle_busy", {63'd0, inv_busy}, 64'd0);
      step();
      sweep(1'b1, -1);
`endif

      // Refill way1 of set 0x12: only way1 valid+tag and fifo may be enabled
      refill_vld = 1'b1;
      refill_idx = 8'h12;
      refill_tag = 28'hABCDEF0;
      refill_way = 1'b1;
      #1;
      e_wen = '1;
      e_wen[58:29] = '0;
      e_d = '0;
      e_d[57] = 1'b1;
      e_d[56:29] = 28'hABCDEF0;
      chk("rf12_cen", {63'd0, sram_cen}, 64'd0);
      chk("rf12_gwen", {63'd0, sram_gwen}, 64'd0);
      chk("rf12_addr", {56'd0, sram_a}, 64'h12);
      chk("rf12_wen", {5'd0, sram_wen}, {5'd0, e_wen});
      chk("rf12_d", {5'd0, sram_d & ~e_wen}, {5'd0, e_d});
      chk("rf12_lkup_rdy", {63'd0, lkup_rdy}, 64'd0);
      step();
      refill_vld = 1'b0;
      lookup("lk12", 8'h12, 28'hABCDEF0, 1'b1, 1'b1, 1'b0);
      #1;
      chk("lk12_vld_drop", {63'd0, rslt_vld}, 64'd0);
      chk("idle_cen", {63'd0, sram_cen}, 64'd1);
      chk("idle_wen", {5'd0, sram_wen}, {5'd0, {59{1'b1}}});

      // Both ways of 0x40, way1 last so fifo points at way0
      refill(8'h40, 28'h1111111, 1'b0);
      refill(8'h40, 28'h2222222, 1'b1);
      lookup("lk40_miss", 8'h40, 28'h3333333, 1'b0, 1'b0, 1'b0);
      lookup("lk40_w1", 8'h40, 28'h2222222, 1'b1, 1'b1, 1'b0);
      lookup("lk40_w0", 8'h40, 28'h1111111, 1'b1, 1'b0, 1'b0);
      // Same tag in both ways: way0 reported
      refill(8'h41, 28'h7777777, 1'b0);
      refill(8'h41, 28'h7777777, 1'b1);
      lookup("lk41_both", 8'h41, 28'h7777777, 1'b1, 1'b0, 1'b0);
      // Only way0 valid: victim is the empty way1
      refill(8'h42, 28'h1234567, 1'b0);
      lookup("lk42", 8'h42, 28'h1234567, 1'b1, 1'b0, 1'b1);
      // Both valid, way0 last: fifo points at way1
      refill(8'h43, 28'h0AAAAAA, 1'b1);
      refill(8'h43, 28'h0BBBBBB, 1'b0);
      lookup("lk43_miss", 8'h43, 28'h0CCCCCC, 1'b0, 1'b0, 1'b1);

      // Refill and lookup collide: refill wins, lookup goes next cycle
      refill_vld = 1'b1;
      refill_idx = 8'h50;
      refill_tag = 28'h5555555;
      refill_way = 1'b0;
      lkup_vld = 1'b1;
      lkup_idx = 8'h50;
      lkup_tag = 28'h5555555;
      #1;
      chk("col_lkup_rdy", {63'd0, lkup_rdy}, 64'd0);
      chk("col_refill_rdy", {63'd0, refill_rdy}, 64'd1);
      chk("col_gwen", {63'd0, sram_gwen}, 64'd0);
      step();
      refill_vld = 1'b0;
      #1;
      chk("col_no_rslt", {63'd0, rslt_vld}, 64'd0);
      chk("col_gwen_rd", {63'd0, sram_gwen}, 64'd1);
      lookup("col_lk", 8'h50, 28'h5555555, 1'b1, 1'b0, 1'b1);

      // Re-request during the sweep at index 50 must not extend it
      sweep(1'b1, 50);
      lookup("post_inv", 8'h12, 28'hABCDEF0, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a sweep at index 100
      inv_all_req = 1'b1;
      step();
      inv_all_req = 1'b0;
      for (int i = 0; i < 100; i++) step();
      #1;
      chk("mid_idx100", {56'd0, sram_a}, 64'd100);
      chk("mid_lkup_rdy", {63'd0, lkup_rdy}, 64'd0);
      chk("mid_refill_rdy", {63'd0, refill_rdy}, 64'd0);
      rst_b = 1'b0;
      #1;
      chk("mrst_busy", {63'd0, inv_busy}, 64'd0);
      chk("mrst_done", {63'd0, inv_done}, 64'd0);
      chk("mrst_cen", {63'd0, sram_cen}, 64'd1);
      chk("mrst_wen", {5'd0, sram_wen}, {5'd0, {59{1'b1}}});
      step();
      step();
      rst_b = 1'b1;
`ifdef AQ_ICACHE_TAG_RST_INV_EN
      #1;
      chk("mrst_restart_idx", {56'd0, sram_a}, 64'd0);
      sweep(1'b0, -1);
`else
      cnt = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (inv_done !== 1'b0 || inv_busy !== 1'b0 || sram_cen !== 1'b1) cnt++;
      end
      chk("mrst_no_done", cnt, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
